// File: rtl/hack_cpu.sv
`default_nettype none
// ============================================================================
// hack_cpu : multi-cycle Hack CPU sequencer with req/ready data memory port
// Revision : 1.0
// ============================================================================
module hack_cpu (
   input  logic        clk,
   input  logic        reset,
   output logic [14:0] rom_addr,
   input  logic [15:0] rom_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [14:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ready,
   output logic [15:0] alu_x,
   output logic [15:0] alu_y,
   output logic [5:0]  alu_ctl,
   input  logic [15:0] alu_out,
   input  logic        alu_zr,
   input  logic        alu_ng,
   output logic [15:0] a_reg,
   output logic [15:0] d_reg,
   output logic [14:0] pc,
   output logic        retire
);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_EXEC   = 3'd1,
      ST_MREAD  = 3'd2,
      ST_ALU    = 3'd3,
      ST_MWRITE = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] a_q, a_d;
   logic [15:0] d_q, d_d;
   logic [14:0] pc_q, pc_d;
   logic [12:0] ir_q, ir_d;
   logic [15:0] mreg_q, mreg_d;
   logic [14:0] waddr_q, waddr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [14:0] pcn_q, pcn_d;

   logic [14:0] w_pc_inc;
   logic        w_jmp;

   assign w_pc_inc = pc_q + 15'd1;
   assign w_jmp    = (ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) | (ir_q[0] & ~alu_ng & ~alu_zr);

   assign rom_addr = pc_q;
   assign alu_x    = d_q;
   assign alu_y    = ir_q[12] ? mreg_q : a_q;
   assign alu_ctl  = ir_q[11:6];
   assign a_reg    = a_q;
   assign d_reg    = d_q;
   assign pc       = pc_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_FETCH;
         a_q     <= 16'd0;
         d_q     <= 16'd0;
         pc_q    <= 15'd0;
         ir_q    <= 13'd0;
         mreg_q  <= 16'd0;
         waddr_q <= 15'd0;
         wdata_q <= 16'd0;
         pcn_q   <= 15'd0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         d_q     <= d_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         mreg_q  <= mreg_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         pcn_q   <= pcn_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      d_d       = d_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      mreg_d    = mreg_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      pcn_d     = pcn_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 15'd0;
      mem_wdata = 16'd0;
      retire    = 1'b0;
      case (state_q)
         ST_FETCH: state_d = ST_EXEC;
         ST_EXEC: begin
            ir_d = rom_data[12:0];
            if (!rom_data[15]) begin
               a_d     = {1'b0, rom_data[14:0]};
               pc_d    = w_pc_inc;
               retire  = 1'b1;
               state_d = ST_FETCH;
            end else begin
               state_d = rom_data[12] ? ST_MREAD : ST_ALU;
            end
         end
         ST_MREAD: begin
            mem_req  = 1'b1;
            mem_addr = a_q[14:0];
            if (mem_ready) begin
               mreg_d  = mem_rdata;
               state_d = ST_ALU;
            end
         end
         ST_ALU: begin
            // Write address and jump target both take A from before this update
            if (ir_q[5]) a_d = alu_out;
            if (ir_q[4]) d_d = alu_out;
            waddr_d = a_q[14:0];
            wdata_d = alu_out;
            pcn_d   = w_jmp ? a_q[14:0] : w_pc_inc;
            if (ir_q[3]) begin
               state_d = ST_MWRITE;
            end else begin
               pc_d    = w_jmp ? a_q[14:0] : w_pc_inc;
               retire  = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_MWRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = waddr_q;
            mem_wdata = wdata_q;
            if (mem_ready) begin
               pc_d    = pcn_q;
               retire  = 1'b1;
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_FETCH;
      endcase
   end

endmodule
`default_nettype wire

// File: doc/hack_cpu.md
# hack_cpu

Multi-cycle Hack CPU sequencer that fetches instructions from program ROM, decodes A- and C-instructions, and holds the A, D and PC registers. It drives the external `c_ALU` instance's operands and control bits, then commits the ALU result to A, D and data memory. The block sits directly upstream of `c_ALU` inside `Nand2Tetris_top` and also consumes its `out`, `zr` and `ng` outputs. Data memory is accessed through a req/ready handshake, so RAM, screen and keyboard may insert wait states.

## Interface
Parameters:
- none (Hack word width 16, address width 15, fixed by the ISA)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- rom_addr  out  15  program ROM address; ROM read data is valid one cycle later
- rom_data  in  16  instruction word
- mem_req  out  1  data memory request, held until accepted
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  15  data address
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data, sampled in the cycle where mem_ready=1
- mem_ready  in  1  completes the current request
- alu_x  out  16  ALU x operand (D)
- alu_y  out  16  ALU y operand (A or M)
- alu_ctl  out  6  {zx,nx,zy,ny,f,no} = instr[11:6]
- alu_out  in  16  ALU result
- alu_zr  in  1  result == 0
- alu_ng  in  1  result < 0
- a_reg, d_reg  out  16  debug views of the A and D registers
- pc  out  15  current program counter
- retire  out  1  one-cycle pulse when an instruction completes

## Operation
States: FETCH, EXEC, MREAD, ALU, MWRITE.
- FETCH: rom_addr = pc. Next state: EXEC.
- EXEC: rom_data is valid and is latched into ir.
  - A-instruction (bit15=0): A <= {0, rom_data[14:0]}, pc <= pc+1, retire=1, next state FETCH.
  - C-instruction (bit15=1; bits 14:13 ignored): if a-bit (bit12)=1, next state MREAD; else next state ALU.
- MREAD: mem_req=1, mem_we=0, mem_addr=A[14:0]. When mem_ready=1, capture mreg <= mem_rdata and go to ALU; otherwise stay.
- ALU: alu_x = D, alu_y = (a ? mreg : A), alu_ctl = ir[11:6]. In this single cycle:
  - if d1 (ir[5]) = 1: A <= alu_out
  - if d2 (ir[4]) = 1: D <= alu_out
  - latch waddr <= old A[14:0] and wdata <= alu_out
  - compute jmp = (j1&ng) | (j2&zr) | (j3&!ng&!zr), with j = ir[2:0]
  - compute pc_next = jmp ? old A[14:0] : pc+1
  - if d3 (ir[3]) = 1: next state MWRITE; else pc <= pc_next, retire=1, next state FETCH.
- MWRITE: mem_req=1, mem_we=1, mem_addr=waddr, mem_wdata=wdata. When mem_ready=1: pc <= pc_next, retire=1, next state FETCH.
- Hack semantics: the M-write address and the jump target both use the A value from before the current instruction's A update. Destination combinations AMD, AM, etc. are all legal.
- pc is 15-bit and wraps from 0x7FFF to 0x0000. Jump 111 is unconditional, 000 never jumps.
- alu_x, alu_y and alu_ctl are driven continuously. alu_out/zr/ng are sampled only in ALU.

## Timing
- Reset values: state FETCH, pc=0, A=0, D=0, ir=0, mreg=0. Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, rom_addr=0.
- Reset asserted mid-transaction drops mem_req immediately (asynchronous). The first fetch after release is at address 0.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are stable while mem_req=1 and mem_ready=0.
  - mem_ready=1 in the first request cycle is a zero-wait completion.
  - mem_req deasserts in the cycle after completion.
  - mem_ready while mem_req=0 is ignored.
- Latency with zero wait states:
  - A-instruction: 2 cycles
  - C-instruction without M: 3 cycles
  - C-instruction with M read or M write: 4 cycles
  - C-instruction with both M read and M write: 5 cycles
  - each wait cycle adds 1
- retire is high for exactly one cycle per instruction, coincident with the pc update.

## Test plan
- Reset then ROM {@5 (0x0005), D=A (0xEC10)}: after 5 cycles D=5, A=5, pc=2; retire pulses at cycles 2 and 5.
- @100, M=D+1 with D=7: mem write to addr 100 with data 8 and mem_we=1; mem_ready delayed 3 cycles keeps req/addr/data stable; pc advances only after ready.
- @3, AM=M+1 with RAM[3]=9: read addr 3, A=10, write to addr 3 (old A) with data 10; total 5 cycles at zero wait.
- @20, D;JGT for D=1, D=0 and D=0x8000: pc becomes 20, pc+1 and pc+1 respectively. Also check @0x7FFF, 0;JMP landing at 0x7FFF, and sequential wrap from 0x7FFF to 0.
- Assert reset during a wait-stated MWRITE: mem_req falls without a clock edge; after release pc=0, A=D=0, the FETCH state is entered and no stale write occurs.
